// File: rtl/bus_arbiter.sv
// Two-requester arbiter (fetch and memory stage) sharing one downstream bus,
// with a single outstanding transaction and an optional round-robin policy.
//
// state  | meaning
// IDLE   | no transaction; sampling i/d requests
// BUSY_I | fetch request on the downstream bus
// BUSY_D | memory-stage request on the downstream bus
// DONE_I | one-cycle fetch response (suppressed if aborted)
// DONE_D | one-cycle memory-stage response
module bus_arbiter #(
  parameter bit FAIR = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [63:0] i_addr,
  input  logic [2:0]  i_size,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [63:0] i_data,
  input  logic        i_abort,
  input  logic        d_valid,
  input  logic [63:0] d_addr,
  input  logic [2:0]  d_size,
  input  logic [7:0]  d_strobe,
  input  logic [63:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [63:0] d_data,
  output logic        m_valid,
  output logic [63:0] m_addr,
  output logic [2:0]  m_size,
  output logic [7:0]  m_strobe,
  output logic [63:0] m_data,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [63:0] m_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic [7:0]  strobe_q, strobe_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] idata_q, idata_d;
  logic [63:0] ddata_q, ddata_d;
  logic        last_fetch_q, last_fetch_d;
  logic        abort_q, abort_d;
  logic        d_sel;
  logic        m_done;

  // Memory stage wins unless round-robin says fetch is owed a turn.
  assign d_sel  = d_valid && (!FAIR || !i_valid || last_fetch_q);
  assign m_done = m_addr_ok && m_data_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      strobe_q     <= '0;
      wdata_q      <= '0;
      idata_q      <= '0;
      ddata_q      <= '0;
      last_fetch_q <= 1'b1;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      strobe_q     <= strobe_d;
      wdata_q      <= wdata_d;
      idata_q      <= idata_d;
      ddata_q      <= ddata_d;
      last_fetch_q <= last_fetch_d;
      abort_q      <= abort_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    strobe_d     = strobe_q;
    wdata_d      = wdata_q;
    idata_d      = idata_q;
    ddata_d      = ddata_q;
    last_fetch_d = last_fetch_q;
    abort_d      = abort_q;
    case (state_q)
      IDLE: begin
        if (d_sel) begin
          addr_d       = d_addr;
          size_d       = d_size;
          strobe_d     = d_strobe;
          wdata_d      = d_wdata;
          last_fetch_d = 1'b0;
          state_d      = BUSY_D;
        end else if (i_valid) begin
          addr_d       = i_addr;
          size_d       = i_size;
          strobe_d     = '0;
          wdata_d      = '0;
          last_fetch_d = 1'b1;
          abort_d      = i_abort;
          state_d      = BUSY_I;
        end
      end
      BUSY_I: begin
        if (i_abort) abort_d = 1'b1;
        if (m_done) begin
          idata_d = m_rdata;
          state_d = DONE_I;
        end
      end
      BUSY_D: begin
        if (m_done) begin
          ddata_d = m_rdata;
          state_d = DONE_D;
        end
      end
      DONE_I, DONE_D: begin
        abort_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_valid   = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign m_addr    = addr_q;
  assign m_size    = size_q;
  assign m_strobe  = strobe_q;
  assign m_data    = wdata_q;
  assign i_addr_ok = (state_q == DONE_I) && !abort_q;
  assign i_data_ok = (state_q == DONE_I) && !abort_q;
  assign i_data    = idata_q;
  assign d_addr_ok = (state_q == DONE_D);
  assign d_data_ok = (state_q == DONE_D);
  assign d_data    = ddata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a priority-mode vector table plus
// hand sequences for abort, mid-transaction reset and round-robin grants.
module tb_bus_arbiter;

  localparam logic [63:0] I_ADDR  = 64'h0000_0000_8000_0000;
  localparam logic [2:0]  I_SIZE  = 3'd2;
  localparam logic [63:0] D_ADDR  = 64'h0000_0000_8000_1000;
  localparam logic [2:0]  D_SIZE  = 3'd3;
  localparam logic [7:0]  D_STRB  = 8'h0F;
  localparam logic [63:0] D_WDATA = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] R1      = 64'h1111_2222_3333_4444;
  localparam logic [63:0] R2      = 64'h0000_0013_0000_0093;
  localparam logic [63:0] R3      = 64'hCAFE_F00D_5555_AAAA;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0, i_abort = 1'b0, d_valid = 1'b0;
  logic        m_addr_ok = 1'b0, m_data_ok = 1'b0;
  logic [63:0] m_rdata = '0;

  logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, m_valid;
  logic [63:0] i_data, d_data, m_addr, m_data;
  logic [2:0]  m_size;
  logic [7:0]  m_strobe;

  logic        f_i_addr_ok, f_i_data_ok, f_d_addr_ok, f_d_data_ok, f_m_valid;
  logic [63:0] f_i_data, f_d_data, f_m_addr, f_m_data;
  logic [2:0]  f_m_size;
  logic [7:0]  f_m_strobe;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.FAIR(1'b0)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(I_ADDR), .i_size(I_SIZE),
    .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_data(i_data), .i_abort(i_abort),
    .d_valid(d_valid), .d_addr(D_ADDR), .d_size(D_SIZE), .d_strobe(D_STRB), .d_wdata(D_WDATA),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_data(d_data),
    .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size), .m_strobe(m_strobe), .m_data(m_data),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  bus_arbiter #(.FAIR(1'b1)) dut_fair (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(I_ADDR), .i_size(I_SIZE),
    .i_addr_ok(f_i_addr_ok), .i_data_ok(f_i_data_ok), .i_data(f_i_data), .i_abort(i_abort),
    .d_valid(d_valid), .d_addr(D_ADDR), .d_size(D_SIZE), .d_strobe(D_STRB), .d_wdata(D_WDATA),
    .d_addr_ok(f_d_addr_ok), .d_data_ok(f_d_data_ok), .d_data(f_d_data),
    .m_valid(f_m_valid), .m_addr(f_m_addr), .m_size(f_m_size), .m_strobe(f_m_strobe), .m_data(f_m_data),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  typedef struct {
    logic        iv, dv, ab, mao, mdo;
    logic [63:0] rdata;
    logic        e_mv, e_isd, e_iok, e_dok;
    logic [63:0] e_idata, e_ddata;
  } vec_t;

  vec_t vt[15];

  task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_valid = 1'b0; d_valid = 1'b0; i_abort = 1'b0;
    m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", 0, {63'd0, m_valid}, 64'd0);
    check("rst_oks", 0, {60'd0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 64'd0);
    check("rst_m_addr", 0, m_addr, 64'd0);
    check("rst_m_strobe", 0, {56'd0, m_strobe}, 64'd0);
    rst = 1'b0;
  endtask

  initial begin
    // iv dv ab mao mdo rdata | mv isd iok dok idata ddata
    vt[0]  = '{1,1,0,0,0,'0, 1,1,0,0,'0,'0};
    vt[1]  = '{1,1,0,1,0,'0, 1,1,0,0,'0,'0};
    vt[2]  = '{1,1,0,1,0,'0, 1,1,0,0,'0,'0};
    vt[3]  = '{1,1,0,0,0,'0, 1,1,0,0,'0,'0};
    vt[4]  = '{1,1,0,1,1,R1, 0,0,0,1,'0,R1};
    vt[5]  = '{1,0,0,1,1,'0, 0,0,0,0,'0,R1};
    vt[6]  = '{1,0,0,1,1,'0, 1,0,0,0,'0,R1};
    vt[7]  = '{1,0,0,0,0,'0, 1,0,0,0,'0,R1};
    vt[8]  = '{1,0,0,0,0,'0, 1,0,0,0,'0,R1};
    vt[9]  = '{1,0,0,0,0,'0, 1,0,0,0,'0,R1};
    vt[10] = '{1,0,0,1,1,R2, 0,0,1,0,R2,R1};
    vt[11] = '{0,0,0,0,0,'0, 0,0,0,0,R2,R1};
    vt[12] = '{0,1,0,0,0,'0, 1,1,0,0,R2,R1};
    vt[13] = '{0,1,0,1,1,R3, 0,1,0,1,R2,R3};
    vt[14] = '{0,0,0,0,0,'0, 0,0,0,0,R2,R3};

    do_reset();
    for (int n = 0; n < 15; n++) begin
      i_valid = vt[n].iv; d_valid = vt[n].dv; i_abort = vt[n].ab;
      m_addr_ok = vt[n].mao; m_data_ok = vt[n].mdo; m_rdata = vt[n].rdata;
      step();
      check("vec_m_valid", n, {63'd0, m_valid}, {63'd0, vt[n].e_mv});
      if (vt[n].e_mv) begin
        check("vec_m_addr", n, m_addr, vt[n].e_isd ? D_ADDR : I_ADDR);
        check("vec_m_strobe", n, {56'd0, m_strobe}, vt[n].e_isd ? {56'd0, D_STRB} : 64'd0);
        check("vec_m_size", n, {61'd0, m_size}, vt[n].e_isd ? {61'd0, D_SIZE} : {61'd0, I_SIZE});
        check("vec_m_data", n, m_data, vt[n].e_isd ? D_WDATA : 64'd0);
      end
      check("vec_i_ok", n, {62'd0, i_addr_ok, i_data_ok}, {62'd0, vt[n].e_iok, vt[n].e_iok});
      check("vec_d_ok", n, {62'd0, d_addr_ok, d_data_ok}, {62'd0, vt[n].e_dok, vt[n].e_dok});
      check("vec_i_data", n, i_data, vt[n].e_idata);
      check("vec_d_data", n, d_data, vt[n].e_ddata);
    end

    // Abort during BUSY_I, abort ignored in BUSY_D, abort coincident with grant.
    do_reset();
    i_valid = 1'b1; step();
    check("ab_grant_i", 0, {63'd0, m_valid}, 64'd1);
    i_abort = 1'b1; i_valid = 1'b0; step();
    i_abort = 1'b0; m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = R2; step();
    check("ab_done_mv", 0, {63'd0, m_valid}, 64'd0);
    check("ab_done_iok", 0, {62'd0, i_addr_ok, i_data_ok}, 64'd0);
    m_addr_ok = 1'b0; m_data_ok = 1'b0; d_valid = 1'b1; step();
    check("ab_idle_mv", 0, {63'd0, m_valid}, 64'd0);
    step();
    check("ab_grant_d", 0, m_addr, D_ADDR);
    i_abort = 1'b1; m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = R1; step();
    check("ab_d_ok", 0, {62'd0, d_addr_ok, d_data_ok}, 64'd3);
    check("ab_d_data", 0, d_data, R1);
    i_abort = 1'b0; d_valid = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0; step();
    i_valid = 1'b1; i_abort = 1'b1; step();
    check("ab_coinc_mv", 0, {63'd0, m_valid}, 64'd1);
    i_abort = 1'b0; i_valid = 1'b0; m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = R3; step();
    check("ab_coinc_iok", 0, {62'd0, i_addr_ok, i_data_ok}, 64'd0);
    m_addr_ok = 1'b0; m_data_ok = 1'b0; step();
    i_valid = 1'b1; step();
    m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = R2; step();
    check("ab_clear_iok", 0, {62'd0, i_addr_ok, i_data_ok}, 64'd3);
    check("ab_clear_idata", 0, i_data, R2);
    i_valid = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0; step();

    // Reset asserted mid-BUSY_D, then a fresh fetch request.
    d_valid = 1'b1; step();
    check("rb_busy_mv", 0, {63'd0, m_valid}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rb_mv", 0, {63'd0, m_valid}, 64'd0);
    check("rb_oks", 0, {60'd0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 64'd0);
    check("rb_m_addr", 0, m_addr, 64'd0);
    check("rb_data", 0, i_data | d_data, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; d_valid = 1'b0; i_valid = 1'b1; step();
    check("rb_grant_mv", 0, {63'd0, m_valid}, 64'd1);
    check("rb_grant_addr", 0, m_addr, I_ADDR);
    m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = R1; step();
    i_valid = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0; step();

    // Round-robin: both requesters valid throughout, grants alternate D, I, D, I.
    do_reset();
    i_valid = 1'b1; d_valid = 1'b1;
    for (int t = 0; t < 4; t++) begin
      automatic bit exp_d = (t % 2 == 0);
      automatic int k = 0;
      automatic logic [63:0] rd = R1 + 64'(t);
      while (!f_m_valid && k < 20) begin
        step();
        k++;
      end
      check("rr_wait", t, {63'd0, f_m_valid}, 64'd1);
      check("rr_addr", t, f_m_addr, exp_d ? D_ADDR : I_ADDR);
      check("rr_strobe", t, {56'd0, f_m_strobe}, exp_d ? {56'd0, D_STRB} : 64'd0);
      check("rr_size", t, {61'd0, f_m_size}, exp_d ? {61'd0, D_SIZE} : {61'd0, I_SIZE});
      check("rr_mdata", t, f_m_data, exp_d ? D_WDATA : 64'd0);
      m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = rd; step();
      m_addr_ok = 1'b0; m_data_ok = 1'b0;
      check("rr_d_ok", t, {62'd0, f_d_addr_ok, f_d_data_ok}, exp_d ? 64'd3 : 64'd0);
      check("rr_i_ok", t, {62'd0, f_i_addr_ok, f_i_data_ok}, exp_d ? 64'd0 : 64'd3);
      check("rr_data", t, exp_d ? f_d_data : f_i_data, rd);
    end
    i_valid = 1'b0; d_valid = 1'b0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
